wb_stage: RTL and testbench



---
 rtl/wb_stage_pkg.sv | 22 ++
 rtl/wb_stage_load_align.sv | 33 +++
 rtl/wb_stage.sv | 124 ++++++++++++
 tb/tb_wb_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the MiniMIPS32 writeback stage: bus widths,
// the zero word and the load operation encoding used between MEM and WB.
package wb_stage_pkg;

    localparam int REG_BUS_W      = 32;
    localparam int REG_ADDR_BUS_W = 5;
    localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;

    // Load op codes; codes 6 and 7 are unused and behave as LD_NONE.
    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LBU  = 3'd2;
    localparam logic [2:0] LD_LH   = 3'd3;
    localparam logic [2:0] LD_LHU  = 3'd4;
    localparam logic [2:0] LD_LW   = 3'd5;

    // True for op codes that take their result from the data memory.
    function automatic logic is_load(input logic [2:0] op);
        return (op >= LD_LB) && (op <= LD_LW);
    endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Load alignment: selects the addressed byte/halfword of a little-endian
// memory word and sign- or zero-extends it. Purely combinational.
module load_align
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word,
    input  logic [2:0]        ldop,
    input  logic [1:0]        addr_lo,
    output logic [DATA_W-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // addr_lo[0] is ignored for halfwords: unaligned halves are not supported.
    assign byte_sel = word[8*addr_lo +: 8];
    assign half_sel = word[16*addr_lo[1] +: 16];

    // Extend the selected field according to the load op.
    always_comb begin
        result = word;
        case (ldop)
            LD_LB:   result = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LD_LBU:  result = {{(DATA_W-8){1'b0}}, byte_sel};
            LD_LH:   result = {{(DATA_W-16){half_sel[15]}}, half_sel};
            LD_LHU:  result = {{(DATA_W-16){1'b0}}, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MiniMIPS32 writeback stage: MEM/WB pipeline register with stall/flush,
// stall-safe capture of the synchronous data-memory response, load
// alignment and register-file write port.
// Optional macro WB_DEBUG_EN adds PC tracing and a retired-instruction count.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              cpu_clk_75M,
    input  logic              cpu_rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [2:0]        mem_ldop,
    input  logic [1:0]        mem_addr_lo,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_waddr,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_valid
`ifdef WB_DEBUG_EN
    ,
    input  logic [31:0]       mem_pc,
    output logic [31:0]       debug_wb_pc,
    output logic [3:0]        debug_wb_rf_wen,
    output logic [31:0]       retire_cnt
`endif
);

    logic              r_valid;
    logic              r_wreg;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_ldop;
    logic [1:0]        r_addr_lo;
    logic              hold_flag;
    logic [DATA_W-1:0] hold_buf;
    logic [DATA_W-1:0] load_word;
    logic [DATA_W-1:0] load_result;

    // WB pipeline register: flush beats stall, stall holds, else capture MEM.
    // The memory word is frozen on the first stalled edge, because the memory
    // presents the next access's data while the pipeline is held.
    always_ff @(posedge cpu_clk_75M or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_valid   <= 1'b0;
            r_wreg    <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_ldop    <= LD_NONE;
            r_addr_lo <= 2'd0;
            hold_flag <= 1'b0;
            hold_buf  <= '0;
        end else if (flush) begin
            r_valid   <= 1'b0;
            r_wreg    <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_ldop    <= LD_NONE;
            r_addr_lo <= 2'd0;
            hold_flag <= 1'b0;
        end else if (stall) begin
            if (!hold_flag && r_valid && is_load(r_ldop)) begin
                hold_buf  <= dm_rdata;
                hold_flag <= 1'b1;
            end
        end else begin
            r_valid   <= mem_valid;
            r_wreg    <= mem_wreg;
            r_waddr   <= mem_waddr;
            r_wdata   <= mem_wdata;
            r_ldop    <= mem_ldop;
            r_addr_lo <= mem_addr_lo;
            hold_flag <= 1'b0;
        end
    end

    assign load_word = hold_flag ? hold_buf : dm_rdata;

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .word    (load_word),
        .ldop    (r_ldop),
        .addr_lo (r_addr_lo),
        .result  (load_result)
    );

    // Writes to $0 are dropped here so the register file never sees them.
    assign wb_we    = r_valid && r_wreg && (r_waddr != '0);
    assign wb_waddr = r_waddr;
    assign wb_valid = r_valid;
    assign wb_wdata = is_load(r_ldop) ? load_result : r_wdata;

`ifdef WB_DEBUG_EN
    logic [31:0] r_pc;
    logic [31:0] r_retire;

    // PC travels with the WB register; retirement counts advancing valid slots.
    always_ff @(posedge cpu_clk_75M or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_pc     <= '0;
            r_retire <= '0;
        end else begin
            if (r_valid && !stall && !flush) begin
                r_retire <= r_retire + 32'd1;
            end
            if (flush) begin
                r_pc <= '0;
            end else if (!stall) begin
                r_pc <= mem_pc;
            end
        end
    end

    assign debug_wb_pc     = r_pc;
    assign debug_wb_rf_wen = {4{wb_we}};
    assign retire_cnt      = r_retire;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed test-plan sequences followed by random
// traffic, checked through an expected-value queue against a reference
// model of the writeback slot. Define WB_DEBUG_EN to cover the debug ports.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, mem_valid, mem_wreg;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_ldop;
    logic [1:0]  mem_addr_lo;
    logic [31:0] dm_rdata;
    logic        wb_we, wb_valid;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
`ifdef WB_DEBUG_EN
    logic [31:0] mem_pc, debug_wb_pc, retire_cnt;
    logic [3:0]  debug_wb_rf_wen;
`endif

    int checks = 0;
    int errors = 0;

    // Expected {valid, we, waddr, wdata} for the current cycle.
    logic [38:0] exp_q[$];
    logic [63:0] dbg_q[$];

    wb_stage dut (
        .cpu_clk_75M (clk),
        .cpu_rst     (rst),
        .stall       (stall),
        .flush       (flush),
        .mem_valid   (mem_valid),
        .mem_wreg    (mem_wreg),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_ldop    (mem_ldop),
        .mem_addr_lo (mem_addr_lo),
        .dm_rdata    (dm_rdata),
        .wb_we       (wb_we),
        .wb_waddr    (wb_waddr),
        .wb_wdata    (wb_wdata),
        .wb_valid    (wb_valid)
`ifdef WB_DEBUG_EN
        ,
        .mem_pc          (mem_pc),
        .debug_wb_pc     (debug_wb_pc),
        .debug_wb_rf_wen (debug_wb_rf_wen),
        .retire_cnt      (retire_cnt)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Contents of the WB slot plus the frozen memory word.
    logic        m_v, m_wr, m_hv;
    logic [4:0]  m_wa;
    logic [31:0] m_wd, m_hb, m_pc, m_ret;
    logic [2:0]  m_op;
    logic [1:0]  m_lo;
    // Inputs seen by the DUT at the coming edge.
    logic        p_st, p_fl, p_v, p_wr;
    logic [4:0]  p_wa;
    logic [31:0] p_wd, p_dm, p_pc;
    logic [2:0]  p_op;
    logic [1:0]  p_lo;

    function automatic logic model_is_load(input logic [2:0] op);
        return op >= 3'd1 && op <= 3'd5;
    endfunction

    function automatic logic [31:0] model_result(input logic [31:0] w, input logic [2:0] op,
                                                  input logic [1:0] lo, input logic [31:0] alu);
        logic [31:0] b, h;
        b = (w >> (8 * lo)) & 32'h0000_00FF;
        h = (w >> (16 * lo[1])) & 32'h0000_FFFF;
        case (op)
            3'd1:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return h;
            3'd5:    return w;
            default: return alu;
        endcase
    endfunction

    task automatic model_reset();
        m_v = 0; m_wr = 0; m_wa = 0; m_wd = 0; m_op = 0; m_lo = 0; m_pc = 0;
        m_hv = 0; m_hb = 0; m_ret = 0;
        p_st = 0; p_fl = 0; p_v = 0; p_wr = 0; p_wa = 0; p_wd = 0; p_op = 0; p_lo = 0;
        p_dm = 0; p_pc = 0;
    endtask

    task automatic model_edge();
        if (m_v && !p_st && !p_fl) m_ret = m_ret + 32'd1;
        if (p_fl) begin
            m_v = 0; m_wr = 0; m_wa = 0; m_wd = 0; m_op = 0; m_lo = 0; m_pc = 0; m_hv = 0;
        end else if (p_st) begin
            if (m_v && model_is_load(m_op) && !m_hv) begin
                m_hb = p_dm;
                m_hv = 1;
            end
        end else begin
            m_v = p_v; m_wr = p_wr; m_wa = p_wa; m_wd = p_wd; m_op = p_op; m_lo = p_lo;
            m_pc = p_pc; m_hv = 0;
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_idle();
        stall = 0; flush = 0; mem_valid = 0; mem_wreg = 0; mem_waddr = 0; mem_wdata = 0;
        mem_ldop = 0; mem_addr_lo = 0; dm_rdata = 0;
`ifdef WB_DEBUG_EN
        mem_pc = 0;
`endif
    endtask

    // One pipeline cycle: advance model over the edge, drive this cycle's
    // inputs, then queue what wb_* must show during this cycle.
    task automatic step(input logic st, input logic fl, input logic v, input logic wr,
                        input logic [4:0] wa, input logic [31:0] wd, input logic [2:0] op,
                        input logic [1:0] lo, input logic [31:0] dm, input logic [31:0] pc);
        logic [31:0] word;
        logic        we;
        @(posedge clk);
        model_edge();
        #1;
        stall = st; flush = fl; mem_valid = v; mem_wreg = wr; mem_waddr = wa;
        mem_wdata = wd; mem_ldop = op; mem_addr_lo = lo; dm_rdata = dm;
`ifdef WB_DEBUG_EN
        mem_pc = pc;
`endif
        p_st = st; p_fl = fl; p_v = v; p_wr = wr; p_wa = wa; p_wd = wd; p_op = op;
        p_lo = lo; p_dm = dm; p_pc = pc;
        word = m_hv ? m_hb : dm;
        we = m_v && m_wr && (m_wa != 5'd0);
        exp_q.push_back({m_v, we, m_wa, model_result(word, m_op, m_lo, m_wd)});
        dbg_q.push_back({m_pc, m_ret});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [38:0] e;
        logic [63:0] d;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            d = dbg_q.pop_front();
            chk("wb_valid", {31'd0, wb_valid}, {31'd0, e[38]});
            chk("wb_we",    {31'd0, wb_we},    {31'd0, e[37]});
            chk("wb_waddr", {27'd0, wb_waddr}, {27'd0, e[36:32]});
            chk("wb_wdata", wb_wdata, e[31:0]);
`ifdef WB_DEBUG_EN
            chk("debug_wb_pc",     debug_wb_pc, d[63:32]);
            chk("retire_cnt",      retire_cnt,  d[31:0]);
            chk("debug_wb_rf_wen", {28'd0, debug_wb_rf_wen}, {28'd0, {4{e[37]}}});
`endif
        end
    end

    task automatic check_reset_outputs();
        chk("rst_wb_we",    {31'd0, wb_we},    32'd0);
        chk("rst_wb_waddr", {27'd0, wb_waddr}, 32'd0);
        chk("rst_wb_wdata", wb_wdata,          32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
`ifdef WB_DEBUG_EN
        chk("rst_debug_wb_pc", debug_wb_pc, 32'd0);
        chk("rst_retire_cnt",  retire_cnt,  32'd0);
`endif
    endtask

    // ---------------- stimulus ----------------
    localparam logic [31:0] DM = 32'h80FF_7F01;

    initial begin
        drive_idle();
        model_reset();
        rst = 1;
        #12;
        check_reset_outputs();
        @(posedge clk); #1;
        rst = 0;

        // Load something, then reset asynchronously mid-cycle.
        step(0, 0, 1, 1, 5'd7, 32'hCAFE_0001, 3'd0, 2'd0, 32'd0, 32'h100);
        step(0, 0, 0, 0, 5'd0, 32'd0, 3'd0, 2'd0, 32'd0, 32'h104);
        @(negedge clk); #2;
        rst = 1;
        #1;
        check_reset_outputs();
        drive_idle();
        model_reset();
        @(posedge clk); #1;
        rst = 0;

        // First instruction after reset release.
        step(0, 0, 1, 1, 5'd3, 32'h1234_5678, 3'd0, 2'd0, 32'd0, 32'h200);
        // Load extraction cases; dm_rdata is meaningful in the cycle after issue.
        step(0, 0, 1, 1, 5'd4, 32'd0, 3'd1, 2'd3, 32'd0, 32'h204); // LB off3
        step(0, 0, 1, 1, 5'd5, 32'd0, 3'd2, 2'd3, DM,    32'h208); // LBU off3
        step(0, 0, 1, 1, 5'd6, 32'd0, 3'd1, 2'd0, DM,    32'h20C); // LB off0
        step(0, 0, 1, 1, 5'd7, 32'd0, 3'd3, 2'd2, DM,    32'h210); // LH off2
        step(0, 0, 1, 1, 5'd8, 32'd0, 3'd4, 2'd1, DM,    32'h214); // LHU off1
        step(0, 0, 1, 1, 5'd9, 32'd0, 3'd5, 2'd2, DM,    32'h218); // LW off2
        // Stall hold: LW in WB for three stalled edges while memory data moves.
        step(0, 0, 1, 1, 5'd10, 32'd0, 3'd5, 2'd0, DM,   32'h21C);
        step(1, 0, 1, 1, 5'd11, 32'h0BAD_F00D, 3'd0, 2'd0, 32'hAAAA_5555, 32'h220);
        step(1, 0, 1, 1, 5'd11, 32'h0BAD_F00D, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h220);
        step(1, 0, 1, 1, 5'd11, 32'h0BAD_F00D, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h220);
        step(0, 0, 1, 1, 5'd11, 32'h0BAD_F00D, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h220);
        // Flush together with stall.
        step(1, 1, 1, 1, 5'd12, 32'h5555_0000, 3'd0, 2'd0, 32'd0, 32'h224);
        // Write to $0 is suppressed.
        step(0, 0, 1, 1, 5'd0, 32'hFFFF_FFFF, 3'd0, 2'd0, 32'd0, 32'h228);
        step(0, 0, 0, 0, 5'd0, 32'd0, 3'd0, 2'd0, 32'd0, 32'h22C);
        // Five valid instructions, one stalled twice, one flushed.
        step(0, 0, 1, 1, 5'd1, 32'h11, 3'd0, 2'd0, 32'd0, 32'h300);
        step(0, 0, 1, 1, 5'd2, 32'h22, 3'd0, 2'd0, 32'd0, 32'h304);
        step(1, 0, 1, 1, 5'd3, 32'h33, 3'd0, 2'd0, 32'd0, 32'h308);
        step(1, 0, 1, 1, 5'd3, 32'h33, 3'd0, 2'd0, 32'd0, 32'h308);
        step(0, 0, 1, 1, 5'd3, 32'h33, 3'd0, 2'd0, 32'd0, 32'h308);
        step(0, 0, 1, 1, 5'd4, 32'h44, 3'd0, 2'd0, 32'd0, 32'h30C);
        step(0, 1, 1, 1, 5'd5, 32'h55, 3'd0, 2'd0, 32'd0, 32'h310);
        step(0, 0, 0, 0, 5'd0, 32'd0, 3'd0, 2'd0, 32'd0, 32'h314);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0,
                 5'($urandom_range(0, 31)), $urandom, 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)), $urandom, $urandom);
        end
        step(0, 0, 0, 0, 5'd0, 32'd0, 3'd0, 2'd0, 32'd0, 32'd0);

        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
